// File: rtl/vid_pattern_gen_if.sv
// Mode-control and video-output bus of vid_pattern_gen.
// master = the generator, slave = whoever drives the controls and consumes the video.
interface vid_pattern_gen_if #(
    parameter int COLOR_W = 8
);
    logic                  I_key;
    logic                  I_mode_wr;
    logic [2:0]            I_mode;
    logic [3*COLOR_W-1:0]  I_solid;
    logic                  O_hs;
    logic                  O_vs;
    logic                  O_de;
    logic [COLOR_W-1:0]    O_r;
    logic [COLOR_W-1:0]    O_g;
    logic [COLOR_W-1:0]    O_b;
    logic [11:0]           O_x;
    logic [11:0]           O_y;
    logic                  O_sof;
    logic [2:0]            O_mode;
    logic [15:0]           O_frame_cnt;

    modport master (
        input  I_key, I_mode_wr, I_mode, I_solid,
        output O_hs, O_vs, O_de, O_r, O_g, O_b, O_x, O_y, O_sof, O_mode, O_frame_cnt
    );

    modport slave (
        output I_key, I_mode_wr, I_mode, I_solid,
        input  O_hs, O_vs, O_de, O_r, O_g, O_b, O_x, O_y, O_sof, O_mode, O_frame_cnt
    );
endinterface

// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern generator: counters -> decode stage -> colour stage,
// with a debounced mode button and host mode load, both applied only at frame wrap.
//
// debounce state | meaning
// DEB_LOW        | debounced key released
// DEB_HIGH       | debounced key pressed
module vid_pattern_gen #(
    parameter int H_RES    = 1280,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int H_TOTAL  = 1650,
    parameter int V_RES    = 720,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int V_TOTAL  = 750,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int COLOR_W  = 8,
    parameter int DEB_CYC  = 270000,
    parameter int BOX_SZ   = 64,
    parameter int BOX_STEP = 4
) (
    input  logic              I_clk,
    input  logic              I_rst,
    vid_pattern_gen_if.master vid
);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(DEB_CYC);
    localparam int H_ACT_S = H_SYNC + H_BP;
    localparam int V_ACT_S = V_SYNC + V_BP;
    localparam int BAR_W   = (H_RES / 8 > 0) ? H_RES / 8 : 1;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0]      H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]      V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [DW-1:0]      DEB_LOAD   = DW'(DEB_CYC - 1);
    localparam logic [BW-1:0]      BAR_LOAD   = BW'(BAR_W - 1);
    localparam logic               HS_ACT     = (HS_POL != 0);
    localparam logic               VS_ACT     = (VS_POL != 0);
    localparam logic [11:0]        BOX_W12    = 12'(BOX_SZ);
    localparam logic [11:0]        BOX_STEP12 = 12'(BOX_STEP);
    localparam logic [11:0]        BOX_MAX    = 12'(H_RES - BOX_SZ);
    localparam logic [11:0]        BOX_Y0     = 12'((V_RES - BOX_SZ) / 2);
    localparam logic [COLOR_W-1:0] C_MAX      = '1;

    typedef enum logic {DEB_LOW, DEB_HIGH} deb_state_t;

    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic                 frame_end;
    logic                 frame_start;
    logic                 de_c;
    logic                 line_start;
    logic [11:0]          x_c;
    logic [11:0]          y_c;

    logic                 hs_s1, vs_s1, de_s1, sof_s1;
    logic [11:0]          x_s1, y_s1;
    logic [3:0]           bar_idx;
    logic [BW-1:0]        bar_left;

    logic [2:0]           bar_rgb;
    logic [COLOR_W-1:0]   ramp_h, ramp_v;
    logic [11:0]          box_dx, box_dy;
    logic                 in_box;
    logic [COLOR_W-1:0]   r_c, g_c, b_c;

    logic                 hs_q, vs_q, de_q, sof_q;
    logic [11:0]          x_q, y_q;
    logic [COLOR_W-1:0]   r_q, g_q, b_q;

    logic [2:0]           mode_cur;
    logic [2:0]           mode_pend;
    logic [15:0]          frame_cnt;
    logic [11:0]          box_x;

    logic                 key_meta, key_sync;
    logic [DW-1:0]        deb_cnt;
    logic                 deb_tc;
    logic                 deb_rise;
    deb_state_t           deb_state, deb_state_nxt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign line_start  = (int'(h_cnt) == H_ACT_S);

    always_comb begin
        de_c = (int'(h_cnt) >= H_ACT_S) && (int'(h_cnt) < H_ACT_S + H_RES) &&
               (int'(v_cnt) >= V_ACT_S) && (int'(v_cnt) < V_ACT_S + V_RES);
        x_c  = '0;
        y_c  = '0;
        if (de_c) begin
            x_c = 12'(int'(h_cnt) - H_ACT_S);
            y_c = 12'(int'(v_cnt) - V_ACT_S);
        end
    end

    // Stage 1: sync/de/coordinates, plus the running bar index (index 8 = residual black)
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            hs_s1    <= ~HS_ACT;
            vs_s1    <= ~VS_ACT;
            de_s1    <= 1'b0;
            sof_s1   <= 1'b0;
            x_s1     <= '0;
            y_s1     <= '0;
            bar_idx  <= '0;
            bar_left <= BAR_LOAD;
        end else begin
            hs_s1  <= (int'(h_cnt) < H_SYNC) ? HS_ACT : ~HS_ACT;
            vs_s1  <= (int'(v_cnt) < V_SYNC) ? VS_ACT : ~VS_ACT;
            de_s1  <= de_c;
            sof_s1 <= frame_start;
            x_s1   <= x_c;
            y_s1   <= y_c;
            if (de_c) begin
                if (line_start) begin
                    bar_idx  <= '0;
                    bar_left <= BAR_LOAD;
                end else if (bar_left == '0) begin
                    bar_left <= BAR_LOAD;
                    if (bar_idx != 4'd8)
                        bar_idx <= bar_idx + 4'd1;
                end else begin
                    bar_left <= bar_left - BW'(1);
                end
            end
        end
    end

    // Stage 2: colour. Offsets wrap negative, so one unsigned compare covers both box edges.
    always_comb begin
        case (bar_idx)
            4'd0:    bar_rgb = 3'b111;
            4'd1:    bar_rgb = 3'b110;
            4'd2:    bar_rgb = 3'b011;
            4'd3:    bar_rgb = 3'b010;
            4'd4:    bar_rgb = 3'b101;
            4'd5:    bar_rgb = 3'b100;
            4'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        ramp_h = COLOR_W'(x_s1 >> 2);
        ramp_v = COLOR_W'(y_s1 >> 2);
        box_dx = x_s1 - box_x;
        box_dy = y_s1 - BOX_Y0;
        in_box = (box_dx < BOX_W12) && (box_dy < BOX_W12);
        r_c = '0;
        g_c = '0;
        b_c = '0;
        if (de_s1) begin
            case (mode_cur)
                3'd0: begin
                    r_c = {COLOR_W{bar_rgb[2]}};
                    g_c = {COLOR_W{bar_rgb[1]}};
                    b_c = {COLOR_W{bar_rgb[0]}};
                end
                3'd1: begin
                    r_c = ramp_h;
                    g_c = ramp_h;
                    b_c = ramp_h;
                end
                3'd2: begin
                    if (x_s1[4:0] == 5'd0 || y_s1[4:0] == 5'd0) begin
                        r_c = C_MAX;
                        g_c = C_MAX;
                        b_c = C_MAX;
                    end
                end
                3'd3: begin
                    if (x_s1[5] ^ y_s1[5]) begin
                        r_c = C_MAX;
                        g_c = C_MAX;
                        b_c = C_MAX;
                    end
                end
                3'd4: {r_c, g_c, b_c} = vid.I_solid;
                3'd5: begin
                    if (in_box)
                        {r_c, g_c, b_c} = vid.I_solid;
                end
                3'd6: begin
                    r_c = ramp_v;
                    g_c = ramp_v;
                    b_c = ramp_v;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            hs_q  <= ~HS_ACT;
            vs_q  <= ~VS_ACT;
            de_q  <= 1'b0;
            sof_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else begin
            hs_q  <= hs_s1;
            vs_q  <= vs_s1;
            de_q  <= de_s1;
            sof_q <= sof_s1;
            x_q   <= x_s1;
            y_q   <= y_s1;
            r_q   <= r_c;
            g_q   <= g_c;
            b_q   <= b_c;
        end
    end

    // Everything visible for a frame is latched on the wrap into h_cnt=v_cnt=0
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mode_cur  <= '0;
            frame_cnt <= '0;
            box_x     <= '0;
        end else if (frame_end) begin
            mode_cur  <= mode_pend;
            frame_cnt <= frame_cnt + 16'd1;
            box_x     <= (box_x + BOX_STEP12 > BOX_MAX) ? '0 : box_x + BOX_STEP12;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= vid.I_key;
            key_sync <= key_meta;
        end
    end

    assign deb_tc = (deb_cnt == '0);

    // Stability timer: reloads whenever the synchronised key agrees with the debounced level
    always_ff @(posedge I_clk) begin
        if (I_rst)
            deb_cnt <= DEB_LOAD;
        else if ((key_sync == (deb_state == DEB_HIGH)) || deb_tc)
            deb_cnt <= DEB_LOAD;
        else
            deb_cnt <= deb_cnt - DW'(1);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst)
            deb_state <= DEB_LOW;
        else
            deb_state <= deb_state_nxt;
    end

    always_comb begin
        deb_state_nxt = deb_state;
        deb_rise      = 1'b0;
        case (deb_state)
            DEB_LOW: begin
                if (key_sync && deb_tc) begin
                    deb_state_nxt = DEB_HIGH;
                    deb_rise      = 1'b1;
                end
            end
            DEB_HIGH: begin
                if (!key_sync && deb_tc)
                    deb_state_nxt = DEB_LOW;
            end
            default: deb_state_nxt = DEB_LOW;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst)
            mode_pend <= '0;
        else if (vid.I_mode_wr)
            mode_pend <= vid.I_mode;
        else if (deb_rise)
            mode_pend <= mode_pend + 3'd1;
    end

    assign vid.O_hs        = hs_q;
    assign vid.O_vs        = vs_q;
    assign vid.O_de        = de_q;
    assign vid.O_sof       = sof_q;
    assign vid.O_x         = x_q;
    assign vid.O_y         = y_q;
    assign vid.O_r         = r_q;
    assign vid.O_g         = g_q;
    assign vid.O_b         = b_q;
    assign vid.O_mode      = mode_cur;
    assign vid.O_frame_cnt = frame_cnt;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen on a small geometry: every output cycle is compared against
// a position-based reference model; two instances cover both sync polarities.
module tb_vid_pattern_gen;
    localparam int H_RES = 16, H_SYNC = 2, H_BP = 2, H_TOTAL = 24;
    localparam int V_RES = 4, V_SYNC = 1, V_BP = 1, V_TOTAL = 8;
    localparam int COLOR_W = 8, DEB_CYC = 8, BOX_SZ = 4, BOX_STEP = 4;
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int M = (1 << COLOR_W) - 1;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        key = 1'b0;
    logic        mode_wr = 1'b0;
    logic [2:0]  mode_in = 3'd0;
    logic [23:0] solid = 24'd0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          since = 0;
    int          fcnt_exp = 0;
    int          box_exp = 0;
    logic [2:0]  mode_exp = 3'd0;
    logic [2:0]  pend_exp = 3'd0;

    vid_pattern_gen_if #(.COLOR_W(COLOR_W)) vp ();
    vid_pattern_gen_if #(.COLOR_W(COLOR_W)) vn ();

    assign vp.I_key = key;
    assign vp.I_mode_wr = mode_wr;
    assign vp.I_mode = mode_in;
    assign vp.I_solid = solid;
    assign vn.I_key = key;
    assign vn.I_mode_wr = mode_wr;
    assign vn.I_mode = mode_in;
    assign vn.I_solid = solid;

    vid_pattern_gen #(
        .H_RES(H_RES), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
        .V_RES(V_RES), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .HS_POL(1), .VS_POL(1), .COLOR_W(COLOR_W), .DEB_CYC(DEB_CYC),
        .BOX_SZ(BOX_SZ), .BOX_STEP(BOX_STEP)
    ) dut_pos (
        .I_clk(I_clk),
        .I_rst(I_rst),
        .vid(vp.master)
    );

    vid_pattern_gen #(
        .H_RES(H_RES), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
        .V_RES(V_RES), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .HS_POL(0), .VS_POL(0), .COLOR_W(COLOR_W), .DEB_CYC(DEB_CYC),
        .BOX_SZ(BOX_SZ), .BOX_STEP(BOX_STEP)
    ) dut_neg (
        .I_clk(I_clk),
        .I_rst(I_rst),
        .vid(vn.master)
    );

    always #5 I_clk = ~I_clk;

    // Expected {hs,vs,de,x,y,r,g,b,sof} for the output s clock edges after reset release.
    function automatic logic [63:0] expect_video(int s, logic [2:0] md, int bx,
                                                 logic [23:0] sol, bit pol);
        int n, h, v, x, y, r, g, b, idx;
        bit hs, vs, de, sof, lit;
        if (s < 2)
            return {12'd0, ~pol, ~pol, 50'd0};
        n   = s - 2;
        h   = n % H_TOTAL;
        v   = (n / H_TOTAL) % V_TOTAL;
        hs  = (h < H_SYNC) ? pol : ~pol;
        vs  = (v < V_SYNC) ? pol : ~pol;
        de  = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_RES) &&
              (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_RES);
        sof = (h == 0) && (v == 0);
        x = de ? h - (H_SYNC + H_BP) : 0;
        y = de ? v - (V_SYNC + V_BP) : 0;
        r = 0; g = 0; b = 0;
        if (de) begin
            case (md)
                3'd0: begin
                    idx = x / (H_RES / 8);
                    case (idx)
                        0: begin r = M; g = M; b = M; end
                        1: begin r = M; g = M; end
                        2: begin g = M; b = M; end
                        3: g = M;
                        4: begin r = M; b = M; end
                        5: r = M;
                        6: b = M;
                        default: ;
                    endcase
                end
                3'd1: begin r = (x / 4) % (M + 1); g = r; b = r; end
                3'd2: begin
                    lit = (x % 32 == 0) || (y % 32 == 0);
                    r = lit ? M : 0; g = r; b = r;
                end
                3'd3: begin
                    lit = (((x / 32) + (y / 32)) % 2) == 1;
                    r = lit ? M : 0; g = r; b = r;
                end
                3'd4: begin r = int'(sol[23:16]); g = int'(sol[15:8]); b = int'(sol[7:0]); end
                3'd5: begin
                    if (x >= bx && x < bx + BOX_SZ &&
                        y >= (V_RES - BOX_SZ) / 2 && y < (V_RES - BOX_SZ) / 2 + BOX_SZ) begin
                        r = int'(sol[23:16]); g = int'(sol[15:8]); b = int'(sol[7:0]);
                    end
                end
                3'd6: begin r = (y / 4) % (M + 1); g = r; b = r; end
                default: ;
            endcase
        end
        return {12'd0, hs, vs, de, 12'(x), 12'(y), 8'(r), 8'(g), 8'(b), sof};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, since, obs, exp);
        end
    endtask

    // One clock: advance the model across the edge, then compare all outputs on the falling edge.
    task automatic tick();
        logic        rst_s;
        logic [2:0]  mode_used;
        int          box_used;
        logic [23:0] solid_used;
        logic [63:0] exp_p, exp_n, obs_p;
        rst_s      = I_rst;
        mode_used  = mode_exp;
        box_used   = box_exp;
        solid_used = solid;
        @(posedge I_clk);
        if (rst_s) begin
            since = 0; mode_exp = 3'd0; pend_exp = 3'd0; fcnt_exp = 0; box_exp = 0;
        end else begin
            since++;
            if (since % FRAME == 0) begin
                mode_exp = pend_exp;
                fcnt_exp = (fcnt_exp + 1) % 65536;
                box_exp  = (box_exp + BOX_STEP > H_RES - BOX_SZ) ? 0 : box_exp + BOX_STEP;
            end
        end
        @(negedge I_clk);
        exp_p = expect_video(since, mode_used, box_used, solid_used, 1'b1);
        exp_n = expect_video(since, mode_used, box_used, solid_used, 1'b0);
        obs_p = {12'd0, vp.O_hs, vp.O_vs, vp.O_de, vp.O_x, vp.O_y,
                 vp.O_r, vp.O_g, vp.O_b, vp.O_sof};
        check("video", obs_p, exp_p);
        check("mode_frame_cnt", {45'd0, vp.O_mode, vp.O_frame_cnt}, {45'd0, mode_exp, 16'(fcnt_exp)});
        check("sync_pol0", {61'd0, vn.O_hs, vn.O_vs, vn.O_de}, {61'd0, exp_n[51:49]});
        solid = $urandom();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to_phase(int ph);
        for (int i = 0; i <= FRAME; i++) begin
            if (since % FRAME == ph) break;
            tick();
        end
    endtask

    task automatic host_write(logic [2:0] v);
        mode_wr = 1'b1;
        mode_in = v;
        tick();
        mode_wr = 1'b0;
        pend_exp = v;
    endtask

    // Key high for len clocks; the debounced edge lands 2 (sync) + DEB_CYC clocks after the press.
    task automatic press(int len, bit host, logic [2:0] hv);
        key = 1'b1;
        for (int i = 1; i <= len || i <= 2 + DEB_CYC; i++) begin
            if (host && i == 2 + DEB_CYC) begin
                mode_wr = 1'b1;
                mode_in = hv;
            end
            tick();
            if (i == len) key = 1'b0;
            if (i == 2 + DEB_CYC) begin
                if (host) begin
                    mode_wr = 1'b0;
                    pend_exp = hv;
                end else if (len >= DEB_CYC) begin
                    pend_exp = pend_exp + 3'd1;
                end
            end
        end
        run(2 + DEB_CYC + 2);
    endtask

    task automatic wait_first_de();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (vp.O_de === 1'b1) break;
            tick();
        end
        check("first_de", 64'(since), 64'(2 + (H_SYNC + H_BP) + H_TOTAL * (V_SYNC + V_BP)));
    endtask

    initial begin
        I_rst = 1'b1;
        run(3);
        I_rst = 1'b0;
        wait_first_de();
        run_to_phase(0);
        run(2 * FRAME);

        for (int m = 1; m < 8; m++) begin
            run_to_phase($urandom_range(30, 170));
            host_write(3'($urandom_range(0, 7)));
            run(3);
            host_write(3'(m));
            run_to_phase(0);
            run((m == 5) ? 5 * FRAME : 2 * FRAME);
        end

        host_write(3'd0);
        run_to_phase(0);
        run(FRAME / 2);
        press($urandom_range(1, DEB_CYC - 1), 1'b0, 3'd0);
        run_to_phase(0);
        run(FRAME / 2);
        press(20, 1'b0, 3'd0);
        run_to_phase(0);
        run(FRAME / 2);
        press(12, 1'b1, 3'd6);
        run_to_phase(0);
        run(FRAME / 2);
        host_write(3'd7);
        press(20, 1'b0, 3'd0);
        run_to_phase(0);
        run(FRAME / 2);

        host_write(3'd3);
        run_to_phase(0);
        run(20);
        for (int i = 0; i < FRAME && vp.O_de !== 1'b1; i++) tick();
        run($urandom_range(1, 8));
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        wait_first_de();
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vid_pattern_gen.md
Name: vid_pattern_gen

Overview:
Parametrised video timing and test-pattern generator feeding DVI_TX_Top in the pixel-clock domain. It is the successor to the fixed 720p testpattern path. Timing geometry and polarity are parameters, and colour depth is generic. It adds debounced button and host mode selection, tear-free mode switching at frame boundaries, pixel coordinate outputs, a frame counter and an animated pattern.

Parameters:
H_RES, 1280, active pixels per line
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch
H_TOTAL, 1650, total pixels per line (must be > H_SYNC+H_BP+H_RES)
V_RES, 720, active lines
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch
V_TOTAL, 750, total lines per frame
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
COLOR_W, 8, bits per colour channel
DEB_CYC, 270000, key debounce stability window (cycles, 2..2^20)
BOX_SZ, 64, moving-box edge (pixels, < H_RES and < V_RES)
BOX_STEP, 4, box advance per frame (pixels)

Ports:
I_clk  in  1  pixel clock
I_rst  in  1  synchronous reset, active high
I_key  in  1  raw asynchronous mode button, active high
I_mode_wr  in  1  host mode-load strobe
I_mode  in  3  host mode value
I_solid  in  3*COLOR_W  solid colour {r,g,b}
O_hs  out  1  horizontal sync
O_vs  out  1  vertical sync
O_de  out  1  data enable
O_r, O_g, O_b  out  COLOR_W each  pixel data
O_x  out  12  active x coordinate, aligned with data
O_y  out  12  active y coordinate, aligned with data
O_sof  out  1  one-cycle start-of-frame pulse
O_mode  out  3  mode currently displayed
O_frame_cnt  out  16  completed frames, wraps

Behaviour:
- Reset is synchronous: all state is applied on the I_clk edge with I_rst=1.
- Reset values: h_cnt=v_cnt=0; O_hs=~HS_POL, O_vs=~VS_POL; O_de=0; O_r/O_g/O_b=0; O_x=O_y=0; O_sof=0; O_mode=0; pending mode=0; O_frame_cnt=0; box_x=0; debounce state=0.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps; v_cnt runs 0..V_TOTAL-1 and wraps to 0.
- hs is active while h_cnt<H_SYNC; vs is active while v_cnt<V_SYNC.
- de is active while h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_RES) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_RES).
- x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP). Outside de, x and y are held at 0.
- Pipeline: 2-stage registered. Stage 1 decodes counters to sync/de/x/y. Stage 2 computes colour.
- O_hs, O_vs, O_de, O_x, O_y and colour are all delayed equally, so latency is 2 cycles from counter value to output.
- When de=0, colour outputs are 0.
- Frame boundary is h_cnt=0, v_cnt=0. At that point:
  - pending mode is copied to O_mode;
  - O_frame_cnt increments (16-bit wrap);
  - box_x updates: if box_x+BOX_STEP > H_RES-BOX_SZ then box_x=0, else box_x+=BOX_STEP;
  - O_sof pulses, aligned 2 cycles later like the other outputs.
- Key path:
  - 2-flop synchroniser, then debounce counter.
  - The debounced level changes only after DEB_CYC consecutive cycles of the opposite synchronised level; any bounce restarts the counter.
  - A debounced rising edge increments pending mode modulo 8 (7 wraps to 0).
- I_mode_wr loads pending mode from I_mode. If I_mode_wr coincides with a key edge, the host load wins.
- Mode changes never take effect mid-frame.
- Patterns, with M=2^COLOR_W-1:
  - 0 colour bars: 8 bars, each H_RES/8 wide (integer), in the order white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a per-line counter, not a divider. Residual pixels take black.
  - 1 horizontal ramp: r=g=b=x[COLOR_W+1:2] (x/4, truncated).
  - 2 grid: white if x[4:0]==0 or y[4:0]==0, else black.
  - 3 checker: white if x[5]^y[5], else black.
  - 4 solid: I_solid, sampled each pixel.
  - 5 moving box: I_solid inside x in [box_x, box_x+BOX_SZ) and y in [(V_RES-BOX_SZ)/2, +BOX_SZ); black elsewhere.
  - 6 vertical ramp: r=g=b=y[COLOR_W+1:2].
  - 7 black.
- Reset mid-frame: the next output cycle after reset holds reset values and the frame restarts at h_cnt=v_cnt=0. No partial-line de is emitted.

Test Plan:
- Small geometry (H_RES=16, H_SYNC=2, H_BP=2, H_TOTAL=24, V_RES=4, V_SYNC=1, V_BP=1, V_TOTAL=8), release reset -> first O_de rising edge exactly 2+4+24*2 cycles after reset release; 16 de cycles per line; 4 de lines per frame; O_sof every 192 cycles; O_frame_cnt 0→1→2.
- Same geometry with HS_POL=0, VS_POL=0 -> O_hs low for 2 cycles per line, O_vs low for 24 cycles per frame; both high after reset.
- Mode 0, H_RES=16 -> x=0,1 white (M,M,M); x=10,11 red (M,0,0); x=14,15 black.
- Key pulse shorter than DEB_CYC (set DEB_CYC=8, pulse 5 cycles) -> O_mode unchanged. Clean 20-cycle press mid-frame -> O_mode 0→1 only at the next O_sof. I_mode_wr=6 on the same cycle as a key edge -> O_mode=6.
- Mode 5, BOX_SZ=4, BOX_STEP=4, H_RES=16 -> box_x sequence 0,4,8,12,0 over successive frames; pixels outside the box are black.
- Assert I_rst at mid-line while de=1 -> next cycle O_de=0, O_hs=~HS_POL, O_mode=0, O_frame_cnt=0; timing restarts identically to the first scenario.
